// File: rtl/psum_accum_if.sv
// Beat bus for psum_accum: the input-tile beat stream and the finished-pixel stream.
// The master drives i_* and receives o_*. The slave (the accumulator) does the opposite.
interface psum_accum_if #(
  parameter int TOUT   = 4,
  parameter int W_PSUM = 32,
  parameter int W_SIZE = 9
);
  logic                     i_vld;
  logic [W_SIZE-1:0]        i_row;
  logic [W_SIZE-1:0]        i_col;
  logic                     i_first_tile;
  logic                     i_last_tile;
  logic [TOUT*W_PSUM-1:0]   i_acc_flat;

  logic                     o_vld;
  logic [W_SIZE-1:0]        o_row;
  logic [W_SIZE-1:0]        o_col;
  logic [TOUT*W_PSUM-1:0]   o_acc_flat;

  modport master (
    output i_vld, i_row, i_col, i_first_tile, i_last_tile, i_acc_flat,
    input  o_vld, o_row, o_col, o_acc_flat
  );

  modport slave (
    input  i_vld, i_row, i_col, i_first_tile, i_last_tile, i_acc_flat,
    output o_vld, o_row, o_col, o_acc_flat
  );
endinterface

// File: rtl/psum_accum.sv
// psum_accum: accumulates per-pixel partial sums across input-channel tiles with an RMW pipeline.
// Build option: define PSUM_SAT_EN to saturate overflowing lanes instead of two's-complement wrap.
module psum_accum #(
  parameter int TOUT   = 4,
  parameter int W_PSUM = 32,
  parameter int W_SIZE = 9,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_clear,
  input  logic [W_SIZE-1:0] q_width,
  input  logic [W_SIZE-1:0] q_height,
  psum_accum_if.slave       bus,
  output logic              o_frame_done,
  output logic              o_err,
  output logic              o_ovf
);

  localparam int DW = TOUT * W_PSUM;
  localparam int IW = 2 * W_SIZE + 1;
  localparam int CW = 2 * W_SIZE;

  // ---------------- Stage S0: address and range check ----------------
  logic [IW-1:0]     s0_idx;
  logic              s0_in_range;
  logic              s0_take;
  logic [ADDR_W-1:0] s0_addr;

  assign s0_idx      = IW'(bus.i_row) * IW'(q_width) + IW'(bus.i_col);
  assign s0_in_range = (bus.i_col < q_width) && (bus.i_row < q_height) && (s0_idx < IW'(DEPTH));
  assign s0_take     = bus.i_vld && s0_in_range;
  assign s0_addr     = ADDR_W'(s0_idx);

  // ---------------- Stage S1 registers ----------------
  logic              s1_vld_reg;
  logic [ADDR_W-1:0] s1_addr_reg;
  logic [W_SIZE-1:0] s1_row_reg;
  logic [W_SIZE-1:0] s1_col_reg;
  logic [DW-1:0]     s1_acc_reg;
  logic              s1_first_reg;
  logic              s1_last_reg;

  // Previous-cycle write, kept for the read-after-write bypass
  logic              wr_vld_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DW-1:0]     wr_data_reg;

  logic [DW-1:0]     mem [DEPTH];
  logic [DW-1:0]     rd_data_reg;
  logic [DW-1:0]     old_data;
  logic [DW-1:0]     sum_data;
  logic [TOUT-1:0]   lane_ovf;
  logic              ram_we;

  always_ff @(posedge clk) begin
    if (rstn) begin
      s1_vld_reg <= 1'b0;
      wr_vld_reg <= 1'b0;
    end else begin
      s1_vld_reg <= s0_take;
      wr_vld_reg <= s1_vld_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (s0_take) begin
      s1_addr_reg  <= s0_addr;
      s1_row_reg   <= bus.i_row;
      s1_col_reg   <= bus.i_col;
      s1_acc_reg   <= bus.i_acc_flat;
      s1_first_reg <= bus.i_first_tile;
      s1_last_reg  <= bus.i_last_tile;
    end
    if (s1_vld_reg) begin
      wr_addr_reg <= s1_addr_reg;
      wr_data_reg <= sum_data;
    end
  end

  // A beat caught in S1 while reset is asserted must not reach the RAM
  assign ram_we = s1_vld_reg && !rstn;

  always_ff @(posedge clk) begin
    if (s0_take) begin
      rd_data_reg <= mem[s0_addr];
    end
    if (ram_we) begin
      mem[s1_addr_reg] <= sum_data;
    end
  end

  // The S0 read of a back-to-back beat misses the write of the beat ahead of it
  assign old_data = (wr_vld_reg && (wr_addr_reg == s1_addr_reg)) ? wr_data_reg : rd_data_reg;

`ifdef PSUM_SAT_EN
  localparam logic [W_PSUM-1:0] SAT_MAX = {1'b0, {(W_PSUM-1){1'b1}}};
  localparam logic [W_PSUM-1:0] SAT_MIN = {1'b1, {(W_PSUM-1){1'b0}}};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < TOUT; gi++) begin : g_lane
      logic signed [W_PSUM-1:0] old_l;
      logic signed [W_PSUM-1:0] acc_l;
      logic signed [W_PSUM-1:0] raw_l;
      logic                     ovf_l;

      assign old_l = old_data[gi*W_PSUM +: W_PSUM];
      assign acc_l = s1_acc_reg[gi*W_PSUM +: W_PSUM];
      assign raw_l = old_l + acc_l;
      assign ovf_l = !s1_first_reg
                     && (old_l[W_PSUM-1] == acc_l[W_PSUM-1])
                     && (raw_l[W_PSUM-1] != acc_l[W_PSUM-1]);
      assign lane_ovf[gi] = ovf_l;
`ifdef PSUM_SAT_EN
      assign sum_data[gi*W_PSUM +: W_PSUM] = s1_first_reg ? acc_l :
                                             ovf_l ? (acc_l[W_PSUM-1] ? SAT_MIN : SAT_MAX) : raw_l;
`else
      assign sum_data[gi*W_PSUM +: W_PSUM] = s1_first_reg ? acc_l : raw_l;
`endif
    end
  endgenerate

  // ---------------- Output stage, frame counter, sticky flags ----------------
  logic              o_vld_reg;
  logic [W_SIZE-1:0] o_row_reg;
  logic [W_SIZE-1:0] o_col_reg;
  logic [DW-1:0]     o_acc_reg;
  logic              frame_done_reg;
  logic              err_reg;
  logic              ovf_reg;
  logic [CW-1:0]     cnt_reg;

  logic              emit;
  logic              frame_end;
  logic [CW-1:0]     cnt_inc;
  logic [CW-1:0]     frame_px;
  logic [CW-1:0]     cnt_next;
  logic              err_next;
  logic              ovf_next;

  assign frame_px = CW'(q_width) * CW'(q_height);

  always_comb begin
    emit      = s1_vld_reg && s1_last_reg;
    cnt_inc   = cnt_reg + 1'b1;
    frame_end = emit && (cnt_inc == frame_px);
    cnt_next  = cnt_reg;
    if (emit) begin
      cnt_next = frame_end ? '0 : cnt_inc;
    end
    // Start of layer beats any simultaneous increment or flag set
    if (i_clear) begin
      cnt_next = '0;
    end
    err_next = i_clear ? 1'b0 : (err_reg || (bus.i_vld && !s0_in_range));
    ovf_next = i_clear ? 1'b0 : (ovf_reg || (s1_vld_reg && (|lane_ovf)));
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      o_vld_reg      <= 1'b0;
      o_row_reg      <= '0;
      o_col_reg      <= '0;
      o_acc_reg      <= '0;
      frame_done_reg <= 1'b0;
      err_reg        <= 1'b0;
      ovf_reg        <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      o_vld_reg      <= emit;
      frame_done_reg <= frame_end;
      if (emit) begin
        o_row_reg <= s1_row_reg;
        o_col_reg <= s1_col_reg;
        o_acc_reg <= sum_data;
      end
      err_reg <= err_next;
      ovf_reg <= ovf_next;
      cnt_reg <= cnt_next;
    end
  end

  assign bus.o_vld      = o_vld_reg;
  assign bus.o_row      = o_row_reg;
  assign bus.o_col      = o_col_reg;
  assign bus.o_acc_flat = o_acc_reg;
  assign o_frame_done   = frame_done_reg;
  assign o_err          = err_reg;
  assign o_ovf          = ovf_reg;

endmodule

// File: tb/tb_psum_accum.sv
// Testbench for psum_accum: directed steps plus a random phase, checked against an
// integer-arithmetic pixel model with a schedule of expected outputs.
module tb_psum_accum;
  localparam int TOUT   = 4;
  localparam int W_PSUM = 32;
  localparam int W_SIZE = 9;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int DW     = TOUT * W_PSUM;

  logic              clk = 1'b0;
  logic              rstn;
  logic              i_clear;
  logic [W_SIZE-1:0] q_width;
  logic [W_SIZE-1:0] q_height;
  logic              o_frame_done;
  logic              o_err;
  logic              o_ovf;

  psum_accum_if #(.TOUT(TOUT), .W_PSUM(W_PSUM), .W_SIZE(W_SIZE)) bus ();

  psum_accum #(
    .TOUT(TOUT), .W_PSUM(W_PSUM), .W_SIZE(W_SIZE), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .i_clear(i_clear),
    .q_width(q_width),
    .q_height(q_height),
    .bus(bus),
    .o_frame_done(o_frame_done),
    .o_err(o_err),
    .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    int            row;
    int            col;
    logic [DW-1:0] acc;
    bit            done;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [int];
  int            cyc    = 0;
  int            checks = 0;
  int            errors = 0;
  int            fcnt   = 0;
  bit            err_m  = 1'b0;
  bit            ovf_m  = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Signed lane add on integers; out-of-range results wrap or clamp
  function automatic logic [W_PSUM-1:0] add_lane(input logic [W_PSUM-1:0] a,
                                                  input logic [W_PSUM-1:0] b,
                                                  output bit ovf);
    longint s, maxv, minv;
    maxv = (longint'(1) << (W_PSUM-1)) - 1;
    minv = -(longint'(1) << (W_PSUM-1));
    s    = longint'($signed(a)) + longint'($signed(b));
    ovf  = (s > maxv) || (s < minv);
`ifdef PSUM_SAT_EN
    if (s > maxv) s = maxv;
    else if (s < minv) s = minv;
`endif
    return s[W_PSUM-1:0];
  endfunction

  function automatic logic [DW-1:0] splat(input int v);
    logic [DW-1:0] r;
    for (int g = 0; g < TOUT; g++) r[g*W_PSUM +: W_PSUM] = W_PSUM'(v);
    return r;
  endfunction

  function automatic logic [DW-1:0] pack_inc(input int base);
    logic [DW-1:0] r;
    for (int g = 0; g < TOUT; g++) r[g*W_PSUM +: W_PSUM] = W_PSUM'(base + g);
    return r;
  endfunction

  function automatic bit in_range(input int r, input int c);
    return (c < int'(q_width)) && (r < int'(q_height)) && (r * int'(q_width) + c < DEPTH);
  endfunction

  function automatic void model_beat(input int r, input int c, input bit f, input bit l,
                                     input logic [DW-1:0] acc);
    int            idx;
    logic [DW-1:0] old, nw;
    bit            o;
    exp_t          e;
    if (!in_range(r, c)) begin
      err_m = 1'b1;
      return;
    end
    idx = r * int'(q_width) + c;
    old = ref_mem.exists(idx) ? ref_mem[idx] : '0;
    for (int g = 0; g < TOUT; g++) begin
      if (f) begin
        nw[g*W_PSUM +: W_PSUM] = acc[g*W_PSUM +: W_PSUM];
      end else begin
        nw[g*W_PSUM +: W_PSUM] = add_lane(old[g*W_PSUM +: W_PSUM], acc[g*W_PSUM +: W_PSUM], o);
        if (o) ovf_m = 1'b1;
      end
    end
    ref_mem[idx] = nw;
    if (l) begin
      fcnt++;
      e.done = (fcnt == int'(q_width) * int'(q_height));
      if (e.done) fcnt = 0;
      e.due = cyc + 2;
      e.row = r;
      e.col = c;
      e.acc = nw;
      exp_q.push_back(e);
    end
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("o_vld", DW'(bus.o_vld), DW'(1'b1));
      chk("o_row", DW'(bus.o_row), DW'(e.row));
      chk("o_col", DW'(bus.o_col), DW'(e.col));
      chk("o_acc_flat", bus.o_acc_flat, e.acc);
      chk("o_frame_done", DW'(o_frame_done), DW'(e.done));
    end else begin
      chk("o_vld_idle", DW'(bus.o_vld), '0);
      chk("o_frame_done_idle", DW'(o_frame_done), '0);
    end
  endtask

  task automatic beat(input int r, input int c, input bit f, input bit l, input logic [DW-1:0] acc);
    bus.i_vld        = 1'b1;
    bus.i_row        = W_SIZE'(r);
    bus.i_col        = W_SIZE'(c);
    bus.i_first_tile = f;
    bus.i_last_tile  = l;
    bus.i_acc_flat   = acc;
    model_beat(r, c, f, l, acc);
    $display("beat cyc=%0d row=%0d col=%0d first=%0b last=%0b acc=%0h", cyc, r, c, f, l, acc);
    tick();
    bus.i_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.i_vld = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_layer();
    i_clear = 1'b1;
    fcnt    = 0;
    err_m   = 1'b0;
    ovf_m   = 1'b0;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_err"}, DW'(o_err), DW'(err_m));
    chk({tag, "_ovf"}, DW'(o_ovf), DW'(ovf_m));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vld"}, DW'(bus.o_vld), '0);
    chk({tag, "_row"}, DW'(bus.o_row), '0);
    chk({tag, "_col"}, DW'(bus.o_col), '0);
    chk({tag, "_acc"}, bus.o_acc_flat, '0);
    chk({tag, "_done"}, DW'(o_frame_done), '0);
    chk({tag, "_err"}, DW'(o_err), '0);
    chk({tag, "_ovf"}, DW'(o_ovf), '0);
  endtask

  initial begin
    logic [DW-1:0] acc, saved;
    int            r, c, idx;
    bit            f, l;

    rstn             = 1'b1;
    i_clear          = 1'b0;
    q_width          = W_SIZE'(4);
    q_height         = W_SIZE'(4);
    bus.i_vld        = 1'b0;
    bus.i_row        = '0;
    bus.i_col        = '0;
    bus.i_first_tile = 1'b0;
    bus.i_last_tile  = 1'b0;
    bus.i_acc_flat   = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rstn = 1'b0;
    idle(1);

    // Full 4x4 frame, single tile per pixel
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        beat(rr, cc, 1'b1, 1'b1, pack_inc(rr * 4 + cc));
    idle(3);

    // Three spread-out tiles into one pixel
    beat(1, 2, 1'b1, 1'b0, splat(10));
    idle(2);
    beat(1, 2, 1'b0, 1'b0, splat(5));
    idle(3);
    beat(1, 2, 1'b0, 1'b1, splat(-3));
    idle(3);

    // Same pixel back-to-back, then with single idle gaps
    beat(0, 0, 1'b1, 1'b0, splat(7));
    beat(0, 0, 1'b0, 1'b0, splat(8));
    beat(0, 0, 1'b0, 1'b1, splat(9));
    idle(3);
    beat(0, 0, 1'b1, 1'b0, splat(7));
    idle(1);
    beat(0, 0, 1'b0, 1'b0, splat(8));
    idle(1);
    beat(0, 0, 1'b0, 1'b1, splat(9));
    idle(3);
    chk_flags("directed");

    // Positive overflow on lane 0
    acc = '0;
    acc[W_PSUM-1:0] = {1'b0, {(W_PSUM-1){1'b1}}};
    beat(2, 2, 1'b1, 1'b0, acc);
    acc[W_PSUM-1:0] = W_PSUM'(1);
    beat(2, 2, 1'b0, 1'b1, acc);
    idle(3);
    chk_flags("overflow");
    clear_layer();
    idle(1);
    chk_flags("cleared");

    // Out-of-range column aliasing pixel (1,0), row out of range, product beyond DEPTH
    beat(1, 0, 1'b1, 1'b0, splat(55));
    idle(2);
    beat(0, 4, 1'b1, 1'b1, splat(99));
    idle(2);
    chk_flags("col_oob");
    beat(4, 0, 1'b1, 1'b1, splat(98));
    beat(1, 0, 1'b0, 1'b1, splat(0));
    idle(3);
    q_width  = W_SIZE'(20);
    q_height = W_SIZE'(20);
    clear_layer();
    beat(15, 0, 1'b1, 1'b1, splat(31));
    beat(12, 15, 1'b1, 1'b1, splat(32));
    idle(3);
    chk_flags("depth");
    q_width  = W_SIZE'(4);
    q_height = W_SIZE'(4);
    clear_layer();
    idle(1);
    chk_flags("restored");

    // Reset one cycle after a beat drops it completely
    saved = ref_mem[15];
    beat(3, 3, 1'b1, 1'b1, splat(77));
    rstn = 1'b1;
    exp_q.delete();
    ref_mem[15] = saved;
    fcnt  = 0;
    err_m = 1'b0;
    ovf_m = 1'b0;
    idle(2);
    chk_all_zero("mid_reset");
    rstn = 1'b0;
    beat(3, 3, 1'b1, 1'b1, splat(123));
    beat(3, 3, 1'b0, 1'b1, splat(1));
    idle(3);

    // Random traffic, including occasional out-of-range beats and large values
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 4));
      c = int'($urandom_range(0, 4));
      l = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 3) == 0);
      if (in_range(r, c)) begin
        idx = r * int'(q_width) + c;
        if (!ref_mem.exists(idx)) f = 1'b1;
      end
      for (int g = 0; g < TOUT; g++) begin
        if ($urandom_range(0, 7) == 0) acc[g*W_PSUM +: W_PSUM] = W_PSUM'($urandom());
        else acc[g*W_PSUM +: W_PSUM] = W_PSUM'(int'($urandom_range(0, 200)) - 100);
      end
      beat(r, c, f, l, acc);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(4);
    chk_flags("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
